pipe_ctrl_unit: RTL and testbench

//  Pipelined control unit. Decodes the ID-stage instruction, registers the control bundle into the ID/EX boundary,
//  and sequences the multi-cycle multiplier/divider.

---
 rtl/pipe_ctrl_unit.sv | 268 ++++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: ID-stage decode, ID/EX control register and mult/div sequencing.
// Optional load-use interlock: define PIPE_CTRL_LOADUSE_EN.
module pipe_ctrl_unit #(
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned OP_W    = 5,
    parameter int unsigned RIDX_W  = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               id_valid,
    input  logic [INSTR_W-1:0] id_instr,
    input  logic               flush,
    input  logic               md_ready,
    output logic               stall,
    output logic               md_start_mul,
    output logic               md_start_div,
    output logic               md_wb,
    output logic               ex_valid,
    output logic [OP_W-1:0]    ex_alu_op,
    output logic               ex_alu_inb,
    output logic               ex_dmwe,
    output logic               ex_rwe,
    output logic               ex_rwd,
    output logic [RIDX_W-1:0]  ex_wb_reg,
    output logic               ex_br_ne,
    output logic               ex_br_lt,
    output logic               ex_jp,
    output logic               ex_jr,
    output logic               ex_bex,
    output logic               ex_setx,
    output logic               ex_is_lw
);

    // Field layout: opcode | rd | rs | rt | shamt | aluop | 2 spare bits
    localparam int unsigned RD_LSB    = INSTR_W - OP_W - RIDX_W;
    localparam int unsigned RS_LSB    = RD_LSB - RIDX_W;
    localparam int unsigned RT_LSB    = RS_LSB - RIDX_W;
    localparam int unsigned ALUOP_LSB = 2;
    localparam int unsigned SHAMT_LSB = ALUOP_LSB + OP_W;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_BNE  = OP_W'(2);
    localparam logic [OP_W-1:0] OP_JAL  = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BLT  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SETX = OP_W'(21);
    localparam logic [OP_W-1:0] OP_BEX  = OP_W'(22);

    localparam logic [OP_W-1:0] ALU_MUL = OP_W'(6);
    localparam logic [OP_W-1:0] ALU_DIV = OP_W'(7);

    localparam logic [RIDX_W-1:0] REG_LINK   = RIDX_W'(31);
    localparam logic [RIDX_W-1:0] REG_STATUS = RIDX_W'(30);

    localparam logic [0:0] RUN     = 1'b0;
    localparam logic [0:0] MD_WAIT = 1'b1;

    typedef struct packed {
        logic              valid;
        logic [OP_W-1:0]   aluOp;
        logic              aluInB;
        logic              dmWe;
        logic              rWe;
        logic              rWd;
        logic [RIDX_W-1:0] wbReg;
        logic              brNe;
        logic              brLt;
        logic              jp;
        logic              jr;
        logic              bex;
        logic              setx;
        logic              isLw;
    } ctrlBundle;

    logic [OP_W-1:0]   idOp;
    logic [OP_W-1:0]   idAluOp;
    logic [RIDX_W-1:0] idRd;
    logic [RIDX_W-1:0] idRs;
    logic [RIDX_W-1:0] idRt;
    logic              unusedBits;

    ctrlBundle idDec;
    ctrlBundle exNext;
    ctrlBundle exQ;
    logic      idIsMul;
    logic      idIsDiv;

    logic [0:0] state;
    logic [0:0] nextState;
    logic       mdWait;
    logic       mdWbC;
    logic       loadUse;
    logic       stallC;
    logic       accept;
    logic       startMulQ;
    logic       startDivQ;

    assign idOp       = id_instr[INSTR_W-1 -: OP_W];
    assign idRd       = id_instr[RD_LSB +: RIDX_W];
    assign idRs       = id_instr[RS_LSB +: RIDX_W];
    assign idRt       = id_instr[RT_LSB +: RIDX_W];
    assign idAluOp    = id_instr[ALUOP_LSB +: OP_W];
    assign unusedBits = ^{id_instr[RT_LSB-1:SHAMT_LSB], id_instr[ALUOP_LSB-1:0]};

    // Instruction decode into the ID/EX control bundle
    always_comb begin
        idDec       = '0;
        idIsMul     = 1'b0;
        idIsDiv     = 1'b0;
        idDec.valid = 1'b1;
        idDec.wbReg = idRd;
        case (idOp)
            OP_R: begin
                idDec.aluOp = idAluOp;
                idIsMul     = (idAluOp == ALU_MUL);
                idIsDiv     = (idAluOp == ALU_DIV);
                // mult/div results are written back later through md_wb
                idDec.rWe   = !(idIsMul || idIsDiv);
            end
            OP_J: begin
                idDec.jp = 1'b1;
            end
            OP_BNE: begin
                idDec.brNe = 1'b1;
            end
            OP_JAL: begin
                idDec.jp    = 1'b1;
                idDec.rWe   = 1'b1;
                idDec.wbReg = REG_LINK;
            end
            OP_JR: begin
                idDec.jr = 1'b1;
            end
            OP_ADDI: begin
                idDec.aluInB = 1'b1;
                idDec.rWe    = 1'b1;
            end
            OP_BLT: begin
                idDec.brLt = 1'b1;
            end
            OP_SW: begin
                idDec.aluInB = 1'b1;
                idDec.dmWe   = 1'b1;
            end
            OP_LW: begin
                idDec.aluInB = 1'b1;
                idDec.rWe    = 1'b1;
                idDec.rWd    = 1'b1;
                idDec.isLw   = 1'b1;
            end
            OP_SETX: begin
                idDec.setx  = 1'b1;
                idDec.rWe   = 1'b1;
                idDec.wbReg = REG_STATUS;
            end
            OP_BEX: begin
                idDec.bex = 1'b1;
            end
            default: begin
                idDec.wbReg = '0;
            end
        endcase
        if (idDec.wbReg == '0) begin
            idDec.rWe = 1'b0;
        end
    end

`ifdef PIPE_CTRL_LOADUSE_EN
    logic idReadsRt;
    logic idReadsRd;

    assign idReadsRt = (idOp == OP_R);
    assign idReadsRd = (idOp == OP_SW) || (idOp == OP_BNE) || (idOp == OP_BLT) || (idOp == OP_JR);

    // A load in EX whose destination is read by the ID instruction; a flush squashes the reader
    assign loadUse = exQ.valid && exQ.isLw && (exQ.wbReg != '0) && id_valid && !flush &&
                     ((idRs == exQ.wbReg) ||
                      (idReadsRt && (idRt == exQ.wbReg)) ||
                      (idReadsRd && (idRd == exQ.wbReg)));
`else
    logic unusedSrc;

    assign loadUse   = 1'b0;
    assign unusedSrc = ^{idRs, idRt};
`endif

    assign mdWait = (state == MD_WAIT) && !md_ready;
    assign mdWbC  = (state == MD_WAIT) && md_ready;
    assign stallC = mdWait || loadUse;
    assign accept = id_valid && !flush && !stallC;

    // Mult/div sequencer next state; a new mul/div may be accepted on the md_ready cycle
    always_comb begin
        nextState = state;
        case (state)
            RUN: begin
                if (accept && (idIsMul || idIsDiv)) begin
                    nextState = MD_WAIT;
                end
            end
            MD_WAIT: begin
                if (accept && (idIsMul || idIsDiv)) begin
                    nextState = MD_WAIT;
                end else if (md_ready) begin
                    nextState = RUN;
                end
            end
            default: begin
                nextState = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // ID/EX next value; while waiting, bubbles keep the mul/div destination for md_wb
    always_comb begin
        exNext = '0;
        if (mdWait) begin
            exNext.wbReg = exQ.wbReg;
        end else if (accept) begin
            exNext = idDec;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exQ       <= '0;
            startMulQ <= 1'b0;
            startDivQ <= 1'b0;
        end else begin
            exQ       <= exNext;
            startMulQ <= accept && idIsMul;
            startDivQ <= accept && idIsDiv;
        end
    end

    assign stall        = stallC;
    assign md_wb        = mdWbC;
    assign md_start_mul = startMulQ;
    assign md_start_div = startDivQ;

    assign ex_valid   = exQ.valid;
    assign ex_alu_op  = exQ.aluOp;
    assign ex_alu_inb = exQ.aluInB;
    assign ex_dmwe    = exQ.dmWe;
    assign ex_rwe     = exQ.rWe;
    assign ex_rwd     = exQ.rWd;
    assign ex_wb_reg  = exQ.wbReg;
    assign ex_br_ne   = exQ.brNe;
    assign ex_br_lt   = exQ.brLt;
    assign ex_jp      = exQ.jp;
    assign ex_jr      = exQ.jr;
    assign ex_bex     = exQ.bex;
    assign ex_setx    = exQ.setx;
    assign ex_is_lw   = exQ.isLw;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed, table-driven bench for pipe_ctrl_unit plus hand sequences for mult/div, reset and load-use.
module tb_pipe_ctrl_unit;

`ifdef PIPE_CTRL_LOADUSE_EN
    localparam logic LU = 1'b1;
`else
    localparam logic LU = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        id_valid = 1'b0;
    logic [31:0] id_instr = '0;
    logic        flush = 1'b0;
    logic        md_ready = 1'b0;
    logic        stall, md_start_mul, md_start_div, md_wb;
    logic        ex_valid, ex_alu_inb, ex_dmwe, ex_rwe, ex_rwd;
    logic [4:0]  ex_alu_op, ex_wb_reg;
    logic        ex_br_ne, ex_br_lt, ex_jp, ex_jr, ex_bex, ex_setx, ex_is_lw;

    pipe_ctrl_unit dut (
        .clock(clock), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .flush(flush), .md_ready(md_ready), .stall(stall),
        .md_start_mul(md_start_mul), .md_start_div(md_start_div), .md_wb(md_wb),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_alu_inb(ex_alu_inb),
        .ex_dmwe(ex_dmwe), .ex_rwe(ex_rwe), .ex_rwd(ex_rwd), .ex_wb_reg(ex_wb_reg),
        .ex_br_ne(ex_br_ne), .ex_br_lt(ex_br_lt), .ex_jp(ex_jp), .ex_jr(ex_jr),
        .ex_bex(ex_bex), .ex_setx(ex_setx), .ex_is_lw(ex_is_lw)
    );

    always #5 clock = ~clock;

    logic [21:0] exVec;
    logic [3:0]  ctlVec;
    assign exVec  = {ex_valid, ex_alu_op, ex_alu_inb, ex_dmwe, ex_rwe, ex_rwd, ex_wb_reg,
                     ex_br_ne, ex_br_lt, ex_jp, ex_jr, ex_bex, ex_setx, ex_is_lw};
    assign ctlVec = {stall, md_start_mul, md_start_div, md_wb};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // flags = {br_ne, br_lt, jp, jr, bex, setx, is_lw}
    function automatic logic [21:0] ex(input logic v, input logic [4:0] op, input logic inb,
                                       input logic dmwe, input logic rwe, input logic rwd,
                                       input logic [4:0] wb, input logic [6:0] fl);
        return {v, op, inb, dmwe, rwe, rwd, wb, fl};
    endfunction

    function automatic logic [31:0] rIns(input logic [4:0] rd, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] alu);
        return {5'd0, rd, rs, rt, 5'd0, alu, 2'b00};
    endfunction

    function automatic logic [31:0] iIns(input logic [4:0] op, input logic [4:0] rd,
                                         input logic [4:0] rs, input logic [16:0] imm);
        return {op, rd, rs, imm};
    endfunction

    function automatic logic [31:0] jIns(input logic [4:0] op, input logic [26:0] tgt);
        return {op, tgt};
    endfunction

    typedef struct {
        logic        idValid;
        logic        fl;
        logic [31:0] instr;
        logic [21:0] expEx;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, iIns(5'd5, 5'd1, 5'd0, 17'd5),     ex(1, 0, 1, 0, 1, 0, 5'd1, 7'b0000000)};
        vecs[1]  = '{1'b1, 1'b0, rIns(5'd3, 5'd1, 5'd2, 5'd0),      ex(1, 0, 0, 0, 1, 0, 5'd3, 7'b0000000)};
        vecs[2]  = '{1'b1, 1'b0, rIns(5'd4, 5'd1, 5'd2, 5'd1),      ex(1, 1, 0, 0, 1, 0, 5'd4, 7'b0000000)};
        vecs[3]  = '{1'b1, 1'b0, rIns(5'd0, 5'd1, 5'd2, 5'd0),      ex(1, 0, 0, 0, 0, 0, 5'd0, 7'b0000000)};
        vecs[4]  = '{1'b1, 1'b0, jIns(5'd3, {5'd7, 22'd100}),       ex(1, 0, 0, 0, 1, 0, 5'd31, 7'b0010000)};
        vecs[5]  = '{1'b1, 1'b0, jIns(5'd21, 27'd77),               ex(1, 0, 0, 0, 1, 0, 5'd30, 7'b0000010)};
        vecs[6]  = '{1'b1, 1'b0, jIns(5'd1, 27'd8),                 ex(1, 0, 0, 0, 0, 0, 5'd0, 7'b0010000)};
        vecs[7]  = '{1'b1, 1'b0, iIns(5'd2, 5'd2, 5'd3, 17'd4),     ex(1, 0, 0, 0, 0, 0, 5'd2, 7'b1000000)};
        vecs[8]  = '{1'b1, 1'b0, iIns(5'd6, 5'd2, 5'd3, 17'd4),     ex(1, 0, 0, 0, 0, 0, 5'd2, 7'b0100000)};
        vecs[9]  = '{1'b1, 1'b0, iIns(5'd4, 5'd31, 5'd0, 17'd0),    ex(1, 0, 0, 0, 0, 0, 5'd31, 7'b0001000)};
        vecs[10] = '{1'b1, 1'b0, iIns(5'd7, 5'd5, 5'd6, 17'd4),     ex(1, 0, 1, 1, 0, 0, 5'd5, 7'b0000000)};
        vecs[11] = '{1'b1, 1'b0, iIns(5'd8, 5'd8, 5'd6, 17'd0),     ex(1, 0, 1, 0, 1, 1, 5'd8, 7'b0000001)};
        vecs[12] = '{1'b1, 1'b0, jIns(5'd22, 27'd50),               ex(1, 0, 0, 0, 0, 0, 5'd0, 7'b0000100)};
        vecs[13] = '{1'b1, 1'b0, iIns(5'd15, 5'd9, 5'd1, 17'd0),    ex(1, 0, 0, 0, 0, 0, 5'd0, 7'b0000000)};
        vecs[14] = '{1'b0, 1'b0, iIns(5'd5, 5'd1, 5'd0, 17'd5),     22'd0};
        vecs[15] = '{1'b1, 1'b1, iIns(5'd7, 5'd5, 5'd6, 17'd4),     22'd0};
        vecs[16] = '{1'b0, 1'b1, rIns(5'd3, 5'd1, 5'd2, 5'd0),      22'd0};
        vecs[17] = '{1'b1, 1'b0, rIns(5'd10, 5'd1, 5'd2, 5'd3),     ex(1, 3, 0, 0, 1, 0, 5'd10, 7'b0000000)};

        // Reset state
        #2 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 check("reset_outputs", {ctlVec, exVec}, 32'd0);
        @(negedge clock) reset = 1'b1;

        // Single-cycle decode table
        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            id_valid = vecs[i].idValid;
            flush    = vecs[i].fl;
            id_instr = vecs[i].instr;
            tick();
            check($sformatf("vec%0d_ex", i), {10'd0, exVec}, {10'd0, vecs[i].expEx});
            check($sformatf("vec%0d_ctl", i), {28'd0, ctlVec}, 32'd0);
        end

        // Asynchronous reset mid-cycle clears outputs without a clock edge
        #2 reset = 1'b0;
        #1 check("async_reset", {ctlVec, exVec}, 32'd0);
        @(negedge clock) reset = 1'b1;

        // mul $3,$1,$2 with md_ready seven cycles after acceptance
        @(negedge clock);
        id_valid = 1'b1; flush = 1'b0; id_instr = rIns(5'd3, 5'd1, 5'd2, 5'd6);
        tick();
        check("mul_accept_ex", {10'd0, exVec}, {10'd0, ex(1, 6, 0, 0, 0, 0, 5'd3, 7'b0)});
        check("mul_start", {28'd0, ctlVec}, {28'd0, 4'b1100});
        @(negedge clock) id_instr = iIns(5'd5, 5'd9, 5'd0, 17'd1);
        for (int k = 2; k <= 7; k++) begin
            tick();
            check($sformatf("mul_wait%0d", k), {6'd0, ctlVec, exVec},
                  {6'd0, 4'b1000, ex(0, 0, 0, 0, 0, 0, 5'd3, 7'b0)});
        end
        @(negedge clock) md_ready = 1'b1;
        #1 check("mul_wb", {6'd0, ctlVec, exVec}, {6'd0, 4'b0001, ex(0, 0, 0, 0, 0, 0, 5'd3, 7'b0)});
        tick();
        check("mul_release", {6'd0, ctlVec, exVec}, {6'd0, 4'b0000, ex(1, 0, 1, 0, 1, 0, 5'd9, 7'b0)});
        @(negedge clock) md_ready = 1'b0;

        // div $6,$1,$2 with flush held during the wait
        @(negedge clock);
        id_instr = rIns(5'd6, 5'd1, 5'd2, 5'd7);
        tick();
        check("div_start", {6'd0, ctlVec, exVec}, {6'd0, 4'b1010, ex(1, 7, 0, 0, 0, 0, 5'd6, 7'b0)});
        @(negedge clock);
        id_instr = iIns(5'd5, 5'd9, 5'd0, 17'd1); flush = 1'b1;
        for (int k = 2; k <= 4; k++) begin
            tick();
            check($sformatf("div_flush_wait%0d", k), {6'd0, ctlVec, exVec},
                  {6'd0, 4'b1000, ex(0, 0, 0, 0, 0, 0, 5'd6, 7'b0)});
        end
        @(negedge clock) md_ready = 1'b1;
        #1 check("div_wb", {6'd0, ctlVec, exVec}, {6'd0, 4'b0001, ex(0, 0, 0, 0, 0, 0, 5'd6, 7'b0)});
        tick();
        check("div_flushed", {6'd0, ctlVec, exVec}, 32'd0);
        @(negedge clock);
        md_ready = 1'b0; flush = 1'b0;

        // Reset two cycles into MD_WAIT; a later md_ready must not write back
        @(negedge clock) id_instr = rIns(5'd5, 5'd1, 5'd2, 5'd6);
        tick();
        check("rst_md_start", {28'd0, ctlVec}, {28'd0, 4'b1100});
        tick();
        check("rst_md_wait", {28'd0, ctlVec}, {28'd0, 4'b1000});
        @(negedge clock);
        reset = 1'b0; id_valid = 1'b0;
        #1 check("rst_md_clear", {ctlVec, exVec}, 32'd0);
        @(negedge clock) reset = 1'b1;
        repeat (2) @(negedge clock);
        md_ready = 1'b1;
        #1 check("rst_md_no_wb", {28'd0, ctlVec}, 32'd0);
        @(negedge clock) md_ready = 1'b0;

        // Load-use: lw $4 then add $5,$4,$1
        @(negedge clock);
        id_valid = 1'b1; id_instr = iIns(5'd8, 5'd4, 5'd6, 17'd0);
        tick();
        @(negedge clock) id_instr = rIns(5'd5, 5'd4, 5'd1, 5'd0);
        #1 check("lu_stall", {31'd0, stall}, {31'd0, LU});
        tick();
        check("lu_bubble", {31'd0, ex_valid}, {31'd0, ~LU});
        check("lu_one_cycle", {31'd0, stall}, 32'd0);
        tick();
        check("lu_add_ex", {10'd0, exVec}, {10'd0, ex(1, 0, 0, 0, 1, 0, 5'd5, 7'b0)});

        // lw $0 never interlocks
        @(negedge clock) id_instr = iIns(5'd8, 5'd0, 5'd6, 17'd0);
        tick();
        check("lw0_ex", {10'd0, exVec}, {10'd0, ex(1, 0, 1, 0, 0, 1, 5'd0, 7'b0000001)});
        @(negedge clock) id_instr = rIns(5'd5, 5'd0, 5'd1, 5'd0);
        #1 check("lw0_no_stall", {31'd0, stall}, 32'd0);

        // jr reads its rd field
        @(negedge clock) id_instr = iIns(5'd8, 5'd7, 5'd6, 17'd0);
        tick();
        @(negedge clock) id_instr = iIns(5'd4, 5'd7, 5'd0, 17'd0);
        #1 check("lu_jr_stall", {31'd0, stall}, {31'd0, LU});

        // Flush beats the load-use interlock
        @(negedge clock) id_instr = iIns(5'd8, 5'd4, 5'd6, 17'd0);
        tick();
        @(negedge clock);
        id_instr = rIns(5'd5, 5'd4, 5'd1, 5'd0); flush = 1'b1;
        #1 check("lu_flush_no_stall", {31'd0, stall}, 32'd0);
        tick();
        check("lu_flush_bubble", {10'd0, exVec}, 32'd0);
        @(negedge clock) flush = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
